fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the execute datapath. It owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, and buffers returned instructions in a 2-entry in-order queue. It delivers each instruction with its PC and PC+4; PC+4 drives the datapath's `newPC` (JAL/JALR link value). On a redirect from branch/jump resolution it flushes the queue and discards in-flight responses.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word fetches
// and buffers returned instructions with their PCs in a 2-entry in-order queue.
module fetch_unit #(
    parameter int unsigned           Data_Width = 32,
    parameter logic [Data_Width-1:0] Reset_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [Data_Width-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [Data_Width-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [Data_Width-1:0] instr,
    output logic [Data_Width-1:0] instr_pc,
    output logic [Data_Width-1:0] instr_pc4,
    input  logic                  redirect,
    input  logic [Data_Width-1:0] redirect_target,
    output logic                  misalign_err
);
    localparam logic [Data_Width-1:0] Pc_Step = Data_Width'(4);

    logic [Data_Width-1:0] fpc_reg;
    logic [1:0]            occ_reg;
    logic [1:0]            inflight_reg;
    logic [1:0]            discard_reg;
    logic [Data_Width-1:0] q_instr_reg [2];
    logic [Data_Width-1:0] q_pc_reg    [2];
    logic [Data_Width-1:0] pcf_reg     [2];
    logic                  pcf_wr_reg;
    logic                  pcf_rd_reg;
    logic                  misalign_reg;

    logic       pop;
    logic       push;
    logic       fire;
    logic       drop;
    logic [1:0] occ_after_pop;
    logic [2:0] credit_used;

    // Occupancy is counted after this cycle's dequeue so a steady stream can
    // sustain one instruction per cycle with only two credits.
    always_comb begin
        pop           = (occ_reg != 2'd0) && instr_ready;
        occ_after_pop = occ_reg - {1'b0, pop};
        credit_used   = {1'b0, occ_after_pop} + {1'b0, inflight_reg};
        imem_req      = !rst && (credit_used < 3'd2) && !redirect;
        fire          = imem_req && imem_ready;
        push          = imem_rvalid && (discard_reg == 2'd0) && !redirect;
        drop          = imem_rvalid && (discard_reg != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_reg      <= Reset_PC;
            misalign_reg <= 1'b0;
        end else if (redirect) begin
            fpc_reg <= {redirect_target[Data_Width-1:2], 2'b00};
            if (redirect_target[1:0] != 2'b00) begin
                misalign_reg <= 1'b1;
            end
        end else if (fire) begin
            fpc_reg <= fpc_reg + Pc_Step;
        end
    end

    // Stale responses stay counted in inflight so credit covers them until they return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_reg <= 2'd0;
            discard_reg  <= 2'd0;
            pcf_wr_reg   <= 1'b0;
            pcf_rd_reg   <= 1'b0;
        end else begin
            inflight_reg <= inflight_reg + {1'b0, fire} - {1'b0, imem_rvalid};
            if (redirect) begin
                discard_reg <= inflight_reg - {1'b0, imem_rvalid};
                pcf_wr_reg  <= 1'b0;
                pcf_rd_reg  <= 1'b0;
            end else begin
                if (drop) begin
                    discard_reg <= discard_reg - 2'd1;
                end
                if (fire) begin
                    pcf_wr_reg <= ~pcf_wr_reg;
                end
                if (push) begin
                    pcf_rd_reg <= ~pcf_rd_reg;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            pcf_reg[pcf_wr_reg] <= fpc_reg;
        end
    end

    // Entry 0 is the head; a push lands in the first slot left free after the pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                q_instr_reg[i] <= '0;
                q_pc_reg[i]    <= '0;
            end
        end else if (redirect) begin
            occ_reg <= 2'd0;
        end else begin
            occ_reg <= occ_after_pop + {1'b0, push};
            if (pop) begin
                q_instr_reg[0] <= q_instr_reg[1];
                q_pc_reg[0]    <= q_pc_reg[1];
            end
            if (push) begin
                q_instr_reg[occ_after_pop[0]] <= imem_rdata;
                q_pc_reg[occ_after_pop[0]]    <= pcf_reg[pcf_rd_reg];
            end
        end
    end

    assign imem_addr    = fpc_reg;
    assign instr_valid  = (occ_reg != 2'd0);
    assign instr        = q_instr_reg[0];
    assign instr_pc     = q_pc_reg[0];
    assign instr_pc4    = q_pc_reg[0] + Pc_Step;
    assign misalign_err = misalign_reg;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (occ_reg == 2'd2)));
    a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
        inflight_reg != 2'd3);
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural in-order memory, expected-PC-stream scoreboard,
// directed scenarios followed by randomized backpressure/latency/redirect traffic.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ready, imem_rvalid;
    logic        instr_valid, instr_ready, redirect, misalign_err;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, instr_pc4, redirect_target;

    int n_vec = 0;
    int n_err = 0;
    int n_hs  = 0;
    int cyc   = 0;
    int lat_min = 1;
    int lat_max = 1;
    int rdy_pct = 100;
    int last_due = 0;
    bit exp_mis = 1'b0;
    logic [31:0] next_pc = RESET_PC;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t mem_q[$];

    fetch_unit #(.Data_Width(32), .Reset_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pc4(instr_pc4),
        .redirect(redirect), .redirect_target(redirect_target),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Program-order model: after reset or a redirect, instructions flow from the
    // (aligned) start address upward by 4, wrapping at 2^32.
    task automatic model_flush(input logic [31:0] pc);
        exp_q.delete();
        next_pc = {pc[31:2], 2'b00};
    endtask

    initial forever begin
        @(negedge clk);
        #2;
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    end

    // In-order memory with per-request latency in [lat_min, lat_max].
    initial begin
        int due;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom();
            end
            imem_ready = (int'($urandom_range(99)) < rdy_pct);
            @(negedge clk);
            if (rst) begin
                mem_q.delete();
                last_due = 0;
            end else if (imem_req && imem_ready) begin
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                mem_q.push_back('{addr: imem_addr, due: due});
                last_due = due;
            end
        end
    end

    // Scoreboard monitor: every head handshake must match the next expected PC.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && instr_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_empty: got pc %h, required no delivery", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn pc=%h instr=%h pc4=%h", instr_pc, instr, instr_pc4);
                    check("sb_pc", instr_pc, e);
                    check("sb_instr", instr, mem_word(e));
                    check("sb_pc4", instr_pc4, e + 32'd4);
                end
            end
        end
    end

    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        instr_ready     = rdy;
        redirect        = redir;
        redirect_target = redir ? tgt : $urandom();
        @(negedge clk);
        #1;
        if (redir) begin
            model_flush(tgt);
            if (tgt[1:0] != 2'b00) exp_mis = 1'b1;
        end
    endtask

    // Returns at the sample point of the first cycle after reset release.
    task automatic do_reset(input bit rdy);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        instr_ready = rdy;
        redirect    = 1'b0;
        model_flush(RESET_PC);
        exp_mis = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_pc4", instr_pc4, 32'd4);
        check("rst_mis", 32'(misalign_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);
    endtask

    task automatic wait_valid(input bit rdy, input string name);
        int n = 0;
        while (!instr_valid && n < 20) begin
            step(rdy, 1'b0, 32'd0);
            n++;
        end
        if (!instr_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: instr_valid got 0, required 1 within 20 cycles", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          fires;
        int          hs_start;
        bit          rd;
        logic [31:0] tgt;
        instr_ready     = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;

        // Sequential fetch, zero-wait memory
        lat_min = 1; lat_max = 1; rdy_pct = 100;
        do_reset(1'b1);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("seq_valid", 32'(instr_valid), 32'd1);
            check("seq_pc", instr_pc, RESET_PC + 32'(4 * k));
            check("seq_pc4", instr_pc4, RESET_PC + 32'(4 * k + 4));
            step(1'b1, 1'b0, 32'd0);
        end

        // Backpressure for 10 cycles
        do_reset(1'b0);
        fires = (imem_req && imem_ready) ? 1 : 0;
        for (int k = 1; k < 10; k++) begin
            step(1'b0, 1'b0, 32'd0);
            if (imem_req && imem_ready) fires++;
        end
        check("bp_accepted", 32'(fires), 32'd2);
        check("bp_req_low", 32'(imem_req), 32'd0);
        check("bp_valid", 32'(instr_valid), 32'd1);
        step(1'b1, 1'b0, 32'd0);
        check("bp_first", instr_pc, RESET_PC);
        step(1'b1, 1'b0, 32'd0);
        check("bp_second", instr_pc, RESET_PC + 32'd4);

        // Redirect with two requests in flight, latency 3
        lat_min = 3; lat_max = 3;
        do_reset(1'b1);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h100);
        check("rd_req_blocked", 32'(imem_req), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("rd_addr", imem_addr, 32'h100);
        check("rd_flushed", 32'(instr_valid), 32'd0);
        wait_valid(1'b1, "rd");
        check("rd_target_pc", instr_pc, 32'h100);

        // Redirect, head handshake and response in the same cycle
        lat_min = 1; lat_max = 1;
        do_reset(1'b1);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h40);
        check("sim_head_valid", 32'(instr_valid), 32'd1);
        step(1'b1, 1'b0, 32'd0);
        check("sim_flushed", 32'(instr_valid), 32'd0);
        check("sim_fpc", imem_addr, 32'h40);
        wait_valid(1'b1, "sim");
        check("sim_target_pc", instr_pc, 32'h40);

        // Misaligned target, sticky error, address wrap
        step(1'b1, 1'b1, 32'h202);
        step(1'b1, 1'b0, 32'd0);
        check("mis_addr", imem_addr, 32'h200);
        check("mis_err", 32'(misalign_err), 32'd1);
        wait_valid(1'b1, "mis");
        check("mis_pc", instr_pc, 32'h200);
        step(1'b1, 1'b1, 32'h300);
        step(1'b1, 1'b0, 32'd0);
        check("mis_sticky", 32'(misalign_err), 32'd1);
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'd0);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid(1'b1, "wrap");
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", instr_pc4, 32'h0000_0000);
        step(1'b1, 1'b0, 32'd0);
        wait_valid(1'b1, "wrap_next");
        check("wrap_next_pc", instr_pc, 32'h0000_0000);

        // Asynchronous reset mid-cycle with a full queue
        do_reset(1'b0);
        repeat (6) step(1'b0, 1'b0, 32'd0);
        check("ar_full_valid", 32'(instr_valid), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_flush(RESET_PC);
        exp_mis = 1'b0;
        #1;
        check("ar_valid_low", 32'(instr_valid), 32'd0);
        check("ar_req_low", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        #1;
        check("ar_resume_req", 32'(imem_req), 32'd1);
        check("ar_resume_addr", imem_addr, RESET_PC);
        repeat (6) step(1'b1, 1'b0, 32'd0);

        // Randomized latency, memory stalls, decode backpressure and redirects
        lat_min = 1; lat_max = 4; rdy_pct = 70;
        hs_start = n_hs;
        for (int k = 0; k < 2000; k++) begin
            rd = (int'($urandom_range(99)) < 3);
            case ($urandom_range(9))
                0:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                1:       tgt = 32'($urandom_range(255));
                default: tgt = {20'h0, 10'($urandom_range(1023)), 2'b00};
            endcase
            step(int'($urandom_range(99)) < 75, rd, tgt);
        end
        repeat (20) step(1'b1, 1'b0, 32'd0);
        check("rand_mis", 32'(misalign_err), 32'(exp_mis));
        check("rand_progress", 32'(n_hs - hs_start >= 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
